edge_detector_bank: RTL and testbench

//  Parametrised multi-channel input conditioner, successor to the single-width posedge stage.
//  Per channel: N-stage synchroniser, debounce filter, configurable edge detect (rise/fall/both),
//  one-cycle pulse, and sticky event flag with clear handshake.

---
 rtl/edge_pkg.sv | 27 ++
 rtl/edge_chan.sv | 104 ++++++++++
 rtl/edge_detector_bank.sv | 48 ++++
 tb/tb_edge_detector_bank.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types and constants for the edge detector bank.
// Optional feature macro: EDGE_COUNT_EN (per-channel saturating pulse counters).
package edge_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam logic [7:0] EDGE_CNT_MAX = 8'd255;

    // True when an accepted transition to new_level is one the mode asks to report.
    function automatic logic edge_match(input edge_mode_t mode, input logic new_level);
        logic hit;
        hit = 1'b0;
        case (mode)
            EDGE_RISE: hit = new_level;
            EDGE_FALL: hit = ~new_level;
            EDGE_BOTH: hit = 1'b1;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One conditioner channel: synchroniser, debounce filter, edge detect,
// one-cycle pulse and sticky event flag.
// Optional feature macro: EDGE_COUNT_EN adds cnt_o, a saturating pulse counter.
//
// Clear handshake: clr_i is a level sampled every clock; while it is high the
// sticky flag is cleared, except that a pulse arriving in the same cycle wins
// and leaves evt_o set. No acknowledge is returned; evt_o itself is the status.
module edge_chan
    import edge_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sig_i,
    input  edge_mode_t mode_i,
    input  logic       clr_i,
    output logic       level_o,
    output logic       pulse_o,
    output logic       evt_o
`ifdef EDGE_COUNT_EN
    ,
    output logic [7:0] cnt_o
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   evt_q, evt_d;
    logic                   s;
    logic                   accept;

    // Debounce counting, edge acceptance, pulse qualification and sticky flag next state.
    always_comb begin
        s       = sync_q[SYNC_STAGES-1];
        accept  = (s != level_q) && (cnt_q == CNT_LAST);
        cnt_d   = cnt_q;
        level_d = level_q;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (accept) begin
            level_d = s;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        pulse_d = accept && edge_match(mode_i, s);
        if (pulse_d) begin
            evt_d = 1'b1;
        end else if (clr_i) begin
            evt_d = 1'b0;
        end else begin
            evt_d = evt_q;
        end
    end

    // State registers: synchroniser chain, debounced level, counter, pulse and flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            evt_q   <= 1'b0;
        end else begin
            sync_q[0] <= sig_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            evt_q   <= evt_d;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;
    assign evt_o   = evt_q;

`ifdef EDGE_COUNT_EN
    logic [7:0] ecnt_q;

    // Saturating pulse count; a clear in the same cycle as a pulse restarts at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ecnt_q <= 8'd0;
        end else if (clr_i) begin
            ecnt_q <= pulse_d ? 8'd1 : 8'd0;
        end else if (pulse_d && (ecnt_q != EDGE_CNT_MAX)) begin
            ecnt_q <= ecnt_q + 8'd1;
        end
    end

    assign cnt_o = ecnt_q;
`endif

endmodule

// File: rtl/edge_detector_bank.sv
// Multi-channel input conditioner: N_CH independent edge_chan instances plus
// an OR of all sticky event flags.
// Optional feature macro: EDGE_COUNT_EN adds cnt_o (8 bits per channel).
module edge_detector_bank
    import edge_pkg::*;
#(
    parameter int N_CH         = 7,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   sig_i,
    input  logic [2*N_CH-1:0] mode_i,
    input  logic [N_CH-1:0]   clr_i,
    output logic [N_CH-1:0]   level_o,
    output logic [N_CH-1:0]   pulse_o,
    output logic [N_CH-1:0]   evt_o,
    output logic              any_evt_o
`ifdef EDGE_COUNT_EN
    ,
    output logic [8*N_CH-1:0] cnt_o
`endif
);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .sig_i  (sig_i[gi]),
            .mode_i (edge_mode_t'(mode_i[2*gi +: 2])),
            .clr_i  (clr_i[gi]),
            .level_o(level_o[gi]),
            .pulse_o(pulse_o[gi]),
            .evt_o  (evt_o[gi])
`ifdef EDGE_COUNT_EN
            ,
            .cnt_o  (cnt_o[8*gi +: 8])
`endif
        );
    end

    assign any_evt_o = |evt_o;

endmodule

// File: tb/tb_edge_detector_bank.sv
// Scoreboard bench for edge_detector_bank: a window-based reference model
// predicts every cycle's outputs into a queue, a negedge monitor pops and compares.
// Optional feature macro: EDGE_COUNT_EN (also checks cnt_o).
module tb_edge_detector_bank;

  localparam int N_CH = 7;
  localparam int S    = 2;
  localparam int D    = 4;
`ifdef EDGE_COUNT_EN
  localparam int W = 3*N_CH + 1 + 8*N_CH;
`else
  localparam int W = 3*N_CH + 1;
`endif

  logic              clk;
  logic              rst;
  logic [N_CH-1:0]   sig;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   clr;
  logic [N_CH-1:0]   level_o, pulse_o, evt_o;
  logic              any_evt_o;
`ifdef EDGE_COUNT_EN
  logic [8*N_CH-1:0] cnt_o;
`endif

  edge_detector_bank #(.N_CH(N_CH), .SYNC_STAGES(S), .DEBOUNCE_CYC(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_i    (sig),
    .mode_i   (mode),
    .clr_i    (clr),
    .level_o  (level_o),
    .pulse_o  (pulse_o),
    .evt_o    (evt_o),
    .any_evt_o(any_evt_o)
`ifdef EDGE_COUNT_EN
    ,
    .cnt_o    (cnt_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // reference model: samp[c][j] is sig[c] sampled j+1 edges ago (0 after reset)
  logic samp [N_CH][S+D-1];
  logic m_level [N_CH];
  logic m_evt   [N_CH];
  int   m_cnt   [N_CH];

  always @(posedge clk) begin
    logic [N_CH-1:0]   e_level, e_pulse, e_evt;
    logic [8*N_CH-1:0] e_cnt;
    logic [W-1:0]      e_vec;
    e_pulse = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (rst) begin
        for (int j = 0; j < S+D-1; j++) samp[c][j] = 1'b0;
        m_level[c] = 1'b0;
        m_evt[c]   = 1'b0;
        m_cnt[c]   = 0;
      end else begin
        logic all_diff;
        logic hit;
        logic [1:0] m;
        all_diff = 1'b1;
        // the last D synchronised values (delayed S edges) must all differ from the level
        for (int j = S-1; j <= S+D-2; j++)
          if (samp[c][j] == m_level[c]) all_diff = 1'b0;
        hit = 1'b0;
        if (all_diff) begin
          m_level[c] = ~m_level[c];
          m = mode[2*c +: 2];
          hit = (m == 2'b11) || (m == 2'b01 && m_level[c]) || (m == 2'b10 && !m_level[c]);
        end
        e_pulse[c] = hit;
        if (hit) m_evt[c] = 1'b1;
        else if (clr[c]) m_evt[c] = 1'b0;
        if (clr[c]) m_cnt[c] = hit ? 1 : 0;
        else if (hit && m_cnt[c] < 255) m_cnt[c] = m_cnt[c] + 1;
        for (int j = S+D-2; j > 0; j--) samp[c][j] = samp[c][j-1];
        samp[c][0] = sig[c];
      end
      e_level[c] = m_level[c];
      e_evt[c]   = m_evt[c];
      e_cnt[8*c +: 8] = m_cnt[c][7:0];
    end
`ifdef EDGE_COUNT_EN
    e_vec = {e_cnt, |e_evt, e_evt, e_pulse, e_level};
`else
    e_vec = {|e_evt, e_evt, e_pulse, e_level};
`endif
    exp_q.push_back(e_vec);
  end

  // monitor: one output word per cycle, compared at the falling edge
  always @(negedge clk) begin
    logic [W-1:0] act, exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
`ifdef EDGE_COUNT_EN
      act = {cnt_o, any_evt_o, evt_o, pulse_o, level_o};
`else
      act = {any_evt_o, evt_o, pulse_o, level_o};
`endif
      checks++;
      if (act !== exp_v) begin
        failures++;
        if (failures <= 30)
          $display("FAIL outputs t=%0t got=%h expected=%h (cnt|any|evt|pulse|level)",
                   $time, act, exp_v);
      end
    end
  end

  // watchdog: the stimulus must finish within a bounded time
  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout t=%0t: stimulus did not complete", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[2*ch +: 2] = m;
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (level_o !== '0 || pulse_o !== '0 || evt_o !== '0 || any_evt_o !== 1'b0) begin
      failures++;
      $display("FAIL %s t=%0t level=%h pulse=%h evt=%h any=%b (expected all 0)",
               tag, $time, level_o, pulse_o, evt_o, any_evt_o);
    end
  endtask

  initial begin
    rst  = 1'b1;
    sig  = '0;
    mode = '0;
    clr  = '0;
    step(3);
    check_idle("reset_state");
    rst = 1'b0;
    step(2);

    // ch0 RISE: clean rising edge
    set_mode(0, 2'b01);
    sig[0] = 1'b1;
    step(10);

    // ch1 RISE: 3-cycle glitch must be filtered
    set_mode(1, 2'b01);
    sig[1] = 1'b1;
    step(3);
    sig[1] = 1'b0;
    step(10);

    // ch2 FALL then BOTH
    set_mode(2, 2'b10);
    sig[2] = 1'b1; step(10);
    sig[2] = 1'b0; step(10);
    set_mode(2, 2'b11);
    sig[2] = 1'b1; step(10);
    sig[2] = 1'b0; step(10);
    sig[2] = 1'b1; step(10);

    // ch3: clear colliding with a new pulse, then a clean clear
    set_mode(3, 2'b01);
    sig[3] = 1'b1; step(10);
    clr[3] = 1'b1; step(1); clr[3] = 1'b0;
    sig[3] = 1'b0; step(10);
    sig[3] = 1'b1;
    step(5);
    clr[3] = 1'b1; step(1); clr[3] = 1'b0;
    step(3);
    clr = '1; step(1); clr = '0;
    step(3);

    // ch4: reset in the middle of a debounce count; ch2 (BOTH, level 1) must not fall-pulse
    set_mode(4, 2'b11);
    sig[4] = 1'b1;
    step(4);
    rst = 1'b1;
    sig[4] = 1'b0;
    step(1);
    check_idle("mid_debounce_reset");
    rst = 1'b0;
    sig[2] = 1'b0;
    step(12);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 9) < 2) sig[c] = ~sig[c];
        clr[c] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 49) == 0) set_mode(c, 2'($urandom_range(0, 3)));
      end
      rst = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst = 1'b0;
    clr = '0;
    step(10);

`ifdef EDGE_COUNT_EN
    // saturation of the pulse counter on ch0
    clr = '1; step(1); clr = '0;
    set_mode(0, 2'b01);
    sig = '0; step(10);
    for (int i = 0; i < 260; i++) begin
      sig[0] = 1'b1; step(2*D);
      sig[0] = 1'b0; step(2*D);
    end
    clr[0] = 1'b1; step(1); clr[0] = 1'b0;
    step(5);
`endif

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
